// File: rtl/cache_line_data_ram.sv
// cache_line_data_ram: byte-lane data RAM with 1-cycle write-first reads and a line fill FSM
module cache_line_data_ram #(
  parameter int data_bits = 32,
  parameter int nr_entries = 32,
  parameter int words_per_line = 4,
  localparam int addr_bits = $clog2(nr_entries),
  localparam int lanes = data_bits / 8,
  localparam int off_bits = $clog2(words_per_line),
  localparam int line_bits = addr_bits - off_bits
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_en,
  input  logic [addr_bits-1:0] read_addr,
  output logic [data_bits-1:0] read_data,
  output logic                 read_valid,
  input  logic                 wr_en,
  input  logic [addr_bits-1:0] write_addr,
  input  logic [data_bits-1:0] write_data,
  input  logic [lanes-1:0]     bytesel,
  input  logic                 fill_start,
  input  logic [line_bits-1:0] fill_line,
  input  logic [data_bits-1:0] fill_data,
  input  logic                 fill_valid,
  output logic                 fill_ready,
  output logic                 fill_busy,
  output logic                 fill_done
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;
  logic [off_bits-1:0] cnt, cnt_n;
  logic [line_bits-1:0] line_q, line_n;
  logic done_n, fill_we, cpu_we;
  logic [addr_bits-1:0] waddr;
  logic [data_bits-1:0] wdata, rd_next;
  logic [lanes-1:0] wlane;
  assign fill_ready = state == FILL;
  assign fill_busy = state == FILL;
  assign fill_we = fill_ready && fill_valid;
  assign cpu_we = state == IDLE && wr_en;
  assign waddr = fill_we ? {line_q, cnt} : write_addr;
  assign wdata = fill_we ? fill_data : write_data;
  assign wlane = fill_we ? {lanes{1'b1}} : (cpu_we ? bytesel : '0);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    line_n = line_q;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (fill_start) begin
        state_n = FILL;
        cnt_n = '0;
        line_n = fill_line;
      end
    end else if (fill_valid) begin
      cnt_n = cnt + 1'b1;
      if (&cnt) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      line_q <= '0;
      fill_done <= 1'b0;
      read_valid <= 1'b0;
      read_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      line_q <= line_n;
      fill_done <= done_n;
      read_valid <= read_en;
      if (read_en) read_data <= rd_next;
    end
  end
  for (genvar i = 0; i < lanes; i++) begin : g_lane
    logic [7:0] lane_mem [nr_entries];
    always_ff @(posedge clk)
      if (wlane[i]) lane_mem[waddr] <= wdata[8*i +: 8];
    assign rd_next[8*i +: 8] = (wlane[i] && waddr == read_addr) ? wdata[8*i +: 8] : lane_mem[read_addr];
  end
endmodule

// File: tb/tb_cache_line_data_ram.sv
// tb_cache_line_data_ram: scoreboard bench for the 32-bit and 64-bit builds
module tb_cache_line_data_ram;
  logic clk = 0, rst = 1;
  logic read_en = 0, wr_en = 0, fill_start = 0, fill_valid = 0;
  logic [4:0] read_addr = 0, write_addr = 0;
  logic [31:0] write_data = 0, fill_data = 0, read_data;
  logic [3:0] bytesel = 0;
  logic [2:0] fill_line = 0;
  logic read_valid, fill_ready, fill_busy, fill_done;
  logic read_en_w = 0, wr_en_w = 0;
  logic [4:0] read_addr_w = 0, write_addr_w = 0;
  logic [63:0] write_data_w = 0, read_data_w;
  logic [7:0] bytesel_w = 0;
  logic read_valid_w, fill_ready_w, fill_busy_w, fill_done_w;
  logic [31:0] q[$];
  logic [63:0] q_w[$];
  int total = 0, passed = 0, done_cnt = 0;

  always #5 clk = ~clk;

  cache_line_data_ram dut (
    .clk(clk), .rst(rst), .read_en(read_en), .read_addr(read_addr), .read_data(read_data),
    .read_valid(read_valid), .wr_en(wr_en), .write_addr(write_addr), .write_data(write_data),
    .bytesel(bytesel), .fill_start(fill_start), .fill_line(fill_line), .fill_data(fill_data),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_busy(fill_busy), .fill_done(fill_done)
  );

  cache_line_data_ram #(.data_bits(64)) dut_w (
    .clk(clk), .rst(rst), .read_en(read_en_w), .read_addr(read_addr_w), .read_data(read_data_w),
    .read_valid(read_valid_w), .wr_en(wr_en_w), .write_addr(write_addr_w), .write_data(write_data_w),
    .bytesel(bytesel_w), .fill_start(1'b0), .fill_line(3'd0), .fill_data(64'd0),
    .fill_valid(1'b0), .fill_ready(fill_ready_w), .fill_busy(fill_busy_w), .fill_done(fill_done_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    wr_en = 1; write_addr = a; write_data = d; bytesel = b;
    tick();
    wr_en = 0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    read_en = 1; read_addr = a; q.push_back(exp);
    tick();
    read_en = 0;
  endtask

  task automatic fill_word(input logic [31:0] d);
    fill_valid = 1; fill_data = d;
    tick();
    fill_valid = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && read_valid) begin
      check("rd_expected", q.size() > 0, 1);
      if (q.size() > 0) check("rd_data", read_data, q.pop_front());
    end
    if (!rst && read_valid_w) begin
      check("rd64_expected", q_w.size() > 0, 1);
      if (q_w.size() > 0) check("rd64_data", read_data_w, q_w.pop_front());
    end
    if (fill_done) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    check("rst_read_data", read_data, 0);
    check("rst_read_valid", read_valid, 0);
    check("rst_fill_ready", fill_ready, 0);
    check("rst_fill_busy", fill_busy, 0);
    check("rst_fill_done", fill_done, 0);
    @(negedge clk) rst = 0;
    tick();
    // partial write merges into earlier full write
    wr(5, 32'hDEADBEEF, 4'b1111);
    wr(5, 32'h000000AA, 4'b0001);
    rd(5, 32'hDEADBEAA);
    check("rd_valid_on", read_valid, 1);
    tick();
    check("rd_valid_pulse", read_valid, 0);
    check("rd_hold", read_data, 32'hDEADBEAA);
    wr(5, 32'h0, 4'b0000);
    rd(5, 32'hDEADBEAA);
    // same-edge read and partial write
    wr(3, 32'h11223344, 4'b1111);
    read_en = 1; read_addr = 3; q.push_back(32'h11BBCC44);
    wr(3, 32'hAABBCCDD, 4'b0110);
    read_en = 0;
    rd(3, 32'h11BBCC44);
    // fill_valid in IDLE is ignored
    wr(0, 32'h12345678, 4'b1111);
    wr(14, 32'h55, 4'b1111);
    fill_word(32'h99);
    rd(0, 32'h12345678);
    // line fill with gaps, ignored wr_en/fill_start mid-fill
    fill_start = 1; fill_line = 2;
    tick();
    fill_start = 0;
    check("fill_busy", fill_busy, 1);
    check("fill_ready", fill_ready, 1);
    fill_word(32'hA0);
    tick();
    fill_word(32'hA1);
    wr_en = 1; write_addr = 9; write_data = 32'hFFFFFFFF; bytesel = 4'hF;
    fill_start = 1; fill_line = 3;
    tick();
    wr_en = 0; fill_start = 0;
    fill_word(32'hA2);
    tick();
    read_en = 1; read_addr = 11; q.push_back(32'hA3);
    fill_word(32'hA3);
    read_en = 0;
    check("fill_done_pulse", fill_done, 1);
    check("fill_busy_drop", fill_busy, 0);
    tick();
    check("fill_done_clear", fill_done, 0);
    check("fill_done_count", done_cnt, 1);
    for (int i = 0; i < 4; i++) rd(5'(8 + i), 32'hA0 + i);
    rd(14, 32'h55);
    // reset mid-fill
    for (int i = 0; i < 4; i++) wr(5'(4 + i), 32'hC0 + i, 4'hF);
    fill_start = 1; fill_line = 1;
    tick();
    fill_start = 0;
    fill_word(32'hB0);
    fill_word(32'hB1);
    rst = 1;
    #1;
    check("abort_read_data", read_data, 0);
    check("abort_read_valid", read_valid, 0);
    check("abort_fill_ready", fill_ready, 0);
    check("abort_fill_busy", fill_busy, 0);
    check("abort_fill_done", fill_done, 0);
    @(negedge clk) rst = 0;
    tick();
    check("post_rst_busy", fill_busy, 0);
    check("post_rst_done", fill_done, 0);
    rd(4, 32'hB0);
    rd(5, 32'hB1);
    rd(6, 32'hC2);
    rd(7, 32'hC3);
    fill_start = 1; fill_line = 1;
    tick();
    fill_start = 0;
    check("refill_busy", fill_busy, 1);
    for (int i = 0; i < 4; i++) fill_word(32'hD0 + i);
    check("refill_done", fill_done, 1);
    rd(4, 32'hD0);
    rd(7, 32'hD3);
    // 64-bit build, outer lanes only
    wr_en_w = 1; write_addr_w = 2; write_data_w = 64'h1122334455667788; bytesel_w = 8'hFF;
    tick();
    write_data_w = 64'hAAAAAAAAAAAAAAAA; bytesel_w = 8'h81;
    tick();
    wr_en_w = 0;
    read_en_w = 1; read_addr_w = 2; q_w.push_back(64'hAA223344556677AA);
    tick();
    read_en_w = 0;
    tick();
    tick();
    check("sb_drained", q.size() + q_w.size(), 0);
    check("fill_done_total", done_cnt, 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cache_line_data_ram.md
CACHE_LINE_DATA_RAM -- requirements
Module: cache_line_data_ram

Interface
REQ-001 The block SHALL have parameter data_bits, default 32: word width; a multiple of 8, range 8..128.
REQ-002 The block SHALL have parameter nr_entries, default 32: words stored; a power of two, at least 2*words_per_line.
REQ-003 The block SHALL have parameter words_per_line, default 4: words per cache line; a power of two, at least 2.
REQ-004 The block SHALL derive addr_bits = $clog2(nr_entries), lanes = data_bits/8, off_bits = $clog2(words_per_line) and line_bits = addr_bits-off_bits.
REQ-005 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port read_en  input  1  read request.
REQ-008 The block SHALL have port read_addr  input  addr_bits  read word address.
REQ-009 The block SHALL have port read_data  output  data_bits  registered read result.
REQ-010 The block SHALL have port read_valid  output  1  read_data updated this cycle.
REQ-011 The block SHALL have port wr_en  input  1  CPU write strobe.
REQ-012 The block SHALL have port write_addr  input  addr_bits  CPU write word address.
REQ-013 The block SHALL have port write_data  input  data_bits  CPU write data.
REQ-014 The block SHALL have port bytesel  input  lanes  byte-lane enables; bit m covers bits 8m+7..8m.
REQ-015 The block SHALL have port fill_start  input  1  begin a line fill.
REQ-016 The block SHALL have port fill_line  input  line_bits  line index to fill.
REQ-017 The block SHALL have port fill_data  input  data_bits  fill word.
REQ-018 The block SHALL have port fill_valid  input  1  fill_data valid.
REQ-019 The block SHALL have port fill_ready  output  1  fill word accepted when high with fill_valid.
REQ-020 The block SHALL have port fill_busy  output  1  fill in progress.
REQ-021 The block SHALL have port fill_done  output  1  one-cycle pulse after the last fill word is written.

Function
REQ-022 The block SHALL implement storage as lanes independent 8-bit-wide arrays of nr_entries each, written per lane.
REQ-023 A read SHALL have 1-cycle latency: read_en high at edge N loads read_data at edge N and asserts read_valid for the following cycle only.
REQ-024 read_data SHALL hold its last value while read_en is low.
REQ-025 On a read and an accepted write to the same address at the same edge, read_data SHALL return the new byte in each written lane and the old byte in every other lane (write-first forwarding).
REQ-026 A CPU write SHALL update only the lanes with a set bytesel bit; wr_en with bytesel all-zero SHALL leave memory unchanged.
REQ-027 The fill FSM SHALL have the states IDLE and FILL; reset state IDLE.
REQ-028 In IDLE, fill_start SHALL latch fill_line, clear the word counter to 0 and enter FILL at the next edge.
REQ-029 In FILL, fill_ready and fill_busy SHALL be 1, and fill_ready SHALL be 0 in IDLE.
REQ-030 Each fill_valid&&fill_ready edge SHALL write all lanes of address {line, counter} and increment the counter.
REQ-031 The write with counter = words_per_line-1 SHALL return the FSM to IDLE and pulse fill_done for the next cycle.
REQ-032 fill_valid without fill_ready SHALL be ignored.
REQ-033 fill_start in FILL SHALL be ignored.
REQ-034 wr_en SHALL be ignored (no memory change) for the whole time the FSM is in FILL.
REQ-035 Reads SHALL remain allowed in FILL, with forwarding per REQ-025 using the fill write (all lanes).
REQ-036 Counter arithmetic SHALL be off_bits wide, and no fill write SHALL fall outside the latched line.

Reset
REQ-037 Reset SHALL set read_data to 0 and read_valid, fill_ready, fill_busy and fill_done to 0, and SHALL set the FSM to IDLE with counter 0.
REQ-038 Reset SHALL NOT initialise memory contents.
REQ-039 Reset during FILL SHALL abort the fill, and partially written words SHALL remain as written.
REQ-040 Deassertion of reset SHALL take effect on the next rising clk, with no spurious fill_done.

Verification
REQ-041 The bench SHALL cover: write 0xDEADBEEF to addr 5 with bytesel 4'b1111, then write 0x000000AA with bytesel 4'b0001, then read addr 5 -> read_data 0xDEADBEAA one cycle later with read_valid high for 1 cycle.
REQ-042 The bench SHALL cover: read addr 3 (holding 0x11223344) in the same cycle as a write of 0xAABBCCDD with bytesel 4'b0110 -> read_data 0x11BBCC44, and a later read also returns 0x11BBCC44.
REQ-043 The bench SHALL cover: fill_start with fill_line 2, then 4 fill_valid words 0xA0..0xA3 with a gap of one idle cycle -> addrs 8..11 hold 0xA0..0xA3, fill_done pulses exactly once, and fill_busy drops in the same cycle.
REQ-044 The bench SHALL cover: wr_en to addr 9 and a second fill_start during FILL -> both ignored, addr 9 holds its fill value, and fill_line is unchanged.
REQ-045 The bench SHALL cover: rst asserted after 2 of 4 fill words -> outputs zero immediately, FSM IDLE, words 0..1 written, words 2..3 unchanged, and a new fill_start is accepted after release.
REQ-046 The bench SHALL cover: data_bits=64 build, write with bytesel 8'h81 -> only lanes 0 and 7 change.
